// File: rtl/dual_port_ram_ctrl.sv
// dual_port_ram_ctrl: dual-port instruction/data RAM with post-reset clear, lane-steered port B and tagged read pipeline.
// Optional macro RAM_COLLISION_FWD_EN: a port A read of the word stored by port B on the same edge returns the merged new word.
module dual_port_ram_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DEPTH_LOG2 = 15,
  parameter int READ_LAT = 2,
  parameter int INIT_CLEAR = 1,
  parameter logic [1:0] MEM_DISABLE = 2'b00,
  parameter logic [1:0] MEM_READ_SEXT = 2'b01,
  parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
  parameter logic [1:0] MEM_WRITE = 2'b11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enA,
  input  logic [ADDR_W-1:0] addrA,
  output logic [31:0]       doutA,
  output logic              readValidA,
  input  logic [1:0]        opB,
  input  logic [1:0]        sizeB,
  input  logic [ADDR_W-1:0] addrB,
  input  logic [31:0]       dinB,
  output logic [31:0]       doutB,
  output logic              readValidB,
  output logic              misalignB,
  output logic              NOTready
);
  typedef enum logic {S_CLEAR, S_RUN} state_t;
  typedef struct packed {
    logic        va;
    logic [31:0] da;
    logic        vb;
    logic        mb;
    logic        sx;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] db;
  } stg_t;
  state_t                r_state, w_next;
  logic [DEPTH_LOG2-1:0] r_clr_idx;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  stg_t                  r_pipe [READ_LAT];
  stg_t                  w_stg, w_last;
  logic [DEPTH_LOG2-1:0] w_idx_a, w_idx_b;
  logic                  w_rdy, w_is_b, w_mis, w_st, w_ld;
  logic [3:0]            w_be;
  logic [31:0]           w_mask, w_wdata, w_old_a, w_old_b, w_rd_a, w_ext;
  logic [15:0]           w_sh;
  logic                  w_unused;
  assign NOTready = (r_state == S_CLEAR);
  assign w_rdy    = ~NOTready & ~reset;
  assign w_idx_a  = addrA[DEPTH_LOG2+1:2];
  assign w_idx_b  = addrB[DEPTH_LOG2+1:2];
  assign w_is_b   = w_rdy & (opB != MEM_DISABLE);
  assign w_mis    = (sizeB == 2'b01 & addrB[0]) | (sizeB[1] & |addrB[1:0]);
  assign w_st     = w_is_b & ~w_mis & (opB == MEM_WRITE);
  assign w_ld     = w_is_b & ~w_mis & (opB == MEM_READ_SEXT | opB == MEM_READ_ZEXT);
  assign w_be     = sizeB == 2'b00 ? 4'b0001 << addrB[1:0] : sizeB == 2'b01 ? (addrB[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata  = sizeB == 2'b00 ? {4{dinB[7:0]}} : sizeB == 2'b01 ? {2{dinB[15:0]}} : dinB;
  assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_old_a  = r_mem[w_idx_a];
  assign w_old_b  = r_mem[w_idx_b];
`ifdef RAM_COLLISION_FWD_EN
  assign w_rd_a   = (w_st && w_idx_a == w_idx_b) ? (w_old_a & ~w_mask) | (w_wdata & w_mask) : w_old_a;
`else
  assign w_rd_a   = w_old_a;
`endif
  assign w_stg    = '{va: enA & w_rdy, da: w_rd_a, vb: w_ld, mb: w_is_b & w_mis, sx: opB == MEM_READ_SEXT,
                      sz: sizeB, off: addrB[1:0], db: w_old_b};
  assign w_last   = r_pipe[READ_LAT-1];
  assign w_sh     = 16'(w_last.db >> {w_last.off, 3'b000});
  assign w_ext    = w_last.sz == 2'b00 ? {{24{w_last.sx & w_sh[7]}}, w_sh[7:0]} :
                    w_last.sz == 2'b01 ? {{16{w_last.sx & w_sh[15]}}, w_sh[15:0]} : w_last.db;
  assign w_unused = ^{addrA[ADDR_W-1:DEPTH_LOG2+2], addrA[1:0], addrB[ADDR_W-1:DEPTH_LOG2+2]};
  // Leave CLEAR once the last word index has been written
  always_comb begin
    w_next = r_state;
    if (r_state == S_CLEAR && r_clr_idx == '1) w_next = S_RUN;
  end
  // FSM state and clear index; reset restarts the clear from word 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= (INIT_CLEAR != 0) ? S_CLEAR : S_RUN;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_next;
      r_clr_idx <= (r_state == S_CLEAR) ? r_clr_idx + 1'b1 : '0;
    end
  end
  // Memory array: zero-fill while clearing, lane-masked store otherwise
  always_ff @(posedge clk) begin
    if (NOTready) r_mem[r_clr_idx] <= '0;
    else if (w_st) r_mem[w_idx_b] <= (w_old_b & ~w_mask) | (w_wdata & w_mask);
  end
  // Read pipeline carries data plus extension control; outputs hold data between pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < READ_LAT; k++) r_pipe[k] <= '0;
      readValidA <= 1'b0;
      readValidB <= 1'b0;
      misalignB  <= 1'b0;
      doutA      <= '0;
      doutB      <= '0;
    end else begin
      r_pipe[0] <= w_stg;
      for (int k = 1; k < READ_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      readValidA <= w_last.va;
      readValidB <= w_last.vb;
      misalignB  <= w_last.mb;
      if (w_last.va) doutA <= w_last.da;
      if (w_last.vb) doutB <= w_ext;
    end
  end
endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// tb_dual_port_ram_ctrl: checks three latency variants against a byte-level reference model plus directed vectors.
module tb_dual_port_ram_ctrl;
  logic        clk = 0, reset = 0, enA = 0;
  logic [31:0] addrA = 0, addrB = 0, dinB = 0;
  logic [1:0]  opB = 0, sizeB = 0;
  logic        rvA [3], rvB [3], misB [3], nr [3];
  logic [31:0] dA [3], dB [3];
  int          lat [3] = '{1, 2, 4};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    dual_port_ram_ctrl #(.ADDR_W(32), .DEPTH_LOG2(4), .READ_LAT(g == 0 ? 1 : g == 1 ? 2 : 4), .INIT_CLEAR(1)) u_dut (
      .clk(clk), .reset(reset), .enA(enA), .addrA(addrA), .doutA(dA[g]), .readValidA(rvA[g]),
      .opB(opB), .sizeB(sizeB), .addrB(addrB), .dinB(dinB), .doutB(dB[g]), .readValidB(rvB[g]),
      .misalignB(misB[g]), .NOTready(nr[g]));
  end
  typedef struct {logic va; logic [31:0] da; logic vb; logic mb; logic [31:0] db;} resp_t;
  typedef struct {logic [1:0] op, sz; logic [31:0] addr, din; logic vb, mb; logic [31:0] db;} vec_t;
  resp_t       pend [5];
  logic [7:0]  bm [64];
  logic [31:0] eda [3], edb [3];
  int          clr_left;
  int          vectors = 0, miscompares = 0;
`ifdef RAM_COLLISION_FWD_EN
  localparam logic [31:0] COL_EXP = 32'h12345678;
`else
  localparam logic [31:0] COL_EXP = 32'h0;
`endif
  task automatic cmp(string name, int inst, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d got=%h exp=%h", name, inst, got, exp);
    end
  endtask
  function automatic logic [31:0] rd(int a, int n, logic sx);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < n; i++) v |= 32'(bm[(a + i) % 64]) << (8 * i);
    if (sx && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 5; k++) pend[k] = '{default: 0};
    for (int i = 0; i < 64; i++) bm[i] = 0;
    for (int i = 0; i < 3; i++) begin eda[i] = 0; edb[i] = 0; end
    clr_left = 16;
  endtask
  task automatic model_edge();
    resp_t r;
    r = '{default: 0};
    if (clr_left > 0) clr_left--;
    else begin
      int a, n, aa;
      logic [31:0] olda;
      a = int'(addrB[5:0]);
      n = sizeB == 0 ? 1 : sizeB == 1 ? 2 : 4;
      aa = int'(addrA[5:2]) * 4;
      olda = rd(aa, 4, 0);
      if (opB != 0) begin
        if (a % n != 0) r.mb = 1;
        else if (opB == 3) for (int i = 0; i < n; i++) bm[(a + i) % 64] = dinB[8*i+:8];
        else begin r.vb = 1; r.db = rd(a, n, opB == 1); end
      end
      r.va = enA;
`ifdef RAM_COLLISION_FWD_EN
      r.da = rd(aa, 4, 0);
`else
      r.da = olda;
`endif
    end
    for (int k = 4; k > 0; k--) pend[k] = pend[k-1];
    pend[0] = r;
    for (int i = 0; i < 3; i++) begin
      if (pend[lat[i]].va) eda[i] = pend[lat[i]].da;
      if (pend[lat[i]].vb) edb[i] = pend[lat[i]].db;
    end
  endtask
  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      cmp("readValidA", i, rvA[i], pend[lat[i]].va);
      cmp("doutA", i, dA[i], eda[i]);
      cmp("readValidB", i, rvB[i], pend[lat[i]].vb);
      cmp("misalignB", i, misB[i], pend[lat[i]].mb);
      cmp("doutB", i, dB[i], edb[i]);
      cmp("NOTready", i, nr[i], clr_left > 0);
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask
  task automatic idle();
    enA = 0;
    opB = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    reset = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vec_t tbl [14];
    int cnt, pc1, pc4;
    tbl[0]  = '{2'd3, 2'd2, 32'h8, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{2'd1, 2'd0, 32'hB, 32'h0,       1'b1, 1'b0, 32'hFFFFFFDE};
    tbl[2]  = '{2'd2, 2'd1, 32'hA, 32'h0,       1'b1, 1'b0, 32'h0000DEAD};
    tbl[3]  = '{2'd3, 2'd0, 32'h9, 32'h7F,      1'b0, 1'b0, 32'h0000DEAD};
    tbl[4]  = '{2'd2, 2'd2, 32'h8, 32'h0,       1'b1, 1'b0, 32'hDEAD7FEF};
    tbl[5]  = '{2'd1, 2'd0, 32'h9, 32'h0,       1'b1, 1'b0, 32'h0000007F};
    tbl[6]  = '{2'd3, 2'd1, 32'h5, 32'hAAAA,    1'b0, 1'b1, 32'h0000007F};
    tbl[7]  = '{2'd2, 2'd2, 32'h6, 32'h0,       1'b0, 1'b1, 32'h0000007F};
    tbl[8]  = '{2'd2, 2'd2, 32'h4, 32'h0,       1'b1, 1'b0, 32'h0};
    tbl[9]  = '{2'd1, 2'd1, 32'h8, 32'h0,       1'b1, 1'b0, 32'h00007FEF};
    tbl[10] = '{2'd1, 2'd1, 32'hA, 32'h0,       1'b1, 1'b0, 32'hFFFFDEAD};
    tbl[11] = '{2'd2, 2'd0, 32'h8, 32'h0,       1'b1, 1'b0, 32'h000000EF};
    tbl[12] = '{2'd3, 2'd3, 32'hC, 32'h11223344, 1'b0, 1'b0, 32'h000000EF};
    tbl[13] = '{2'd2, 2'd3, 32'hC, 32'h0,       1'b1, 1'b0, 32'h11223344};
    #2;
    do_reset();
    cnt = 0;
    while (nr[1] && cnt < 100) begin step(); cnt++; end
    cmp("clear_cycles", 1, cnt, 16);
    for (int i = 0; i < 16; i++) begin
      enA = 1;
      addrA = i * 4;
      step();
      idle();
      repeat (5) step();
      cmp("readback_zero", 2, dA[2], 32'h0);
    end
    enA = 1; addrA = 32'h10; opB = 3; sizeB = 2; addrB = 32'h10; dinB = 32'h12345678;
    step();
    idle();
    step();
    step();
    cmp("collision_valid", 1, rvA[1], 1);
    cmp("collision_doutA", 1, dA[1], COL_EXP);
    repeat (3) step();
    for (int t = 0; t < 14; t++) begin
      opB = tbl[t].op; sizeB = tbl[t].sz; addrB = tbl[t].addr; dinB = tbl[t].din;
      step();
      idle();
      step();
      step();
      cmp("tbl_readValidB", t, rvB[1], tbl[t].vb);
      cmp("tbl_misalignB", t, misB[1], tbl[t].mb);
      cmp("tbl_doutB", t, dB[1], tbl[t].db);
    end
    pc1 = 0;
    pc4 = 0;
    for (int j = 0; j < 12; j++) begin
      enA = j < 8;
      addrA = j * 4;
      step();
      pc1 += int'(rvA[0]);
      pc4 += int'(rvA[2]);
    end
    cmp("b2b_pulses_lat1", 0, pc1, 8);
    cmp("b2b_pulses_lat4", 2, pc4, 8);
    repeat (400) begin
      enA = 1'($urandom); addrA = $urandom; opB = 2'($urandom); sizeB = 2'($urandom);
      addrB = $urandom; dinB = $urandom;
      step();
    end
    enA = 1; addrA = 0; opB = 2; sizeB = 2; addrB = 4;
    step();
    step();
    do_reset();
    cnt = 0;
    repeat (16) begin
      step();
      cnt += int'(rvA[0]) + int'(rvA[2]) + int'(rvB[0]) + int'(rvB[2]);
    end
    cmp("post_reset_pulses", 0, cnt, 0);
    idle();
    repeat (6) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
